tone_seq: RTL and testbench

TONE_SEQ -- requirements
Module: tone_seq

---
 rtl/tone_seq_pkg.sv | 14 +
 rtl/tone_div.sv | 32 +++
 rtl/tone_seq.sv | 126 ++++++++++++
 tb/tb_tone_seq.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/tone_seq_pkg.sv
// Shared definitions for the tone sequencer: playback state encoding and
// default parameter values.
package tone_seq_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_t;

    localparam int DEF_ENTRY_W     = 8;
    localparam int DEF_DEPTH       = 10;
    localparam int DEF_STEP_CYCLES = 1000;

endpackage

// File: rtl/tone_div.sv
// Half-period divider: toggles tone every `half` clocks after a reload.
// A zero half-period is a rest and holds tone low.
module tone_div #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         reload,
    input  logic [W-1:0] half,
    output logic         tone
);

    logic [W-1:0] cnt;

    // The half-period is sampled only on reload or on a toggle, so a table
    // write never disturbs a count already in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            tone <= 1'b0;
        end else if (reload) begin
            cnt  <= half;
            tone <= 1'b0;
        end else if (cnt == W'(1)) begin
            cnt  <= half;
            tone <= ~tone;
        end else if (cnt != '0) begin
            cnt  <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/tone_seq.sv
// Tone sequencer: plays a DEPTH-entry table of half-periods, STEP_CYCLES
// clocks per entry. Define TONE_SEQ_LOOP_EN to add the `loop` input.
module tone_seq
    import tone_seq_pkg::*;
#(
    parameter  int ENTRY_W     = DEF_ENTRY_W,
    parameter  int DEPTH       = DEF_DEPTH,
    parameter  int STEP_CYCLES = DEF_STEP_CYCLES,
    localparam int ADDR_W      = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
`ifdef TONE_SEQ_LOOP_EN
    input  logic               loop,
`endif
    input  logic               wr_en,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [ENTRY_W-1:0] wr_data,
    output logic               busy,
    output logic [ADDR_W-1:0]  step,
    output logic               tone_out,
    output logic               done
);

    localparam int                TMR_W     = $clog2(STEP_CYCLES);
    localparam logic [TMR_W-1:0]  LAST_TICK = TMR_W'(STEP_CYCLES - 1);
    localparam logic [ADDR_W-1:0] LAST_STEP = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W + 1)'(DEPTH);

    state_t             state, state_nxt;
    logic [ADDR_W-1:0]  step_q, step_nxt;
    logic [TMR_W-1:0]   timer, timer_nxt;
    logic               done_nxt;
    logic               reload;
    logic               loop_on;
    logic [ENTRY_W-1:0] table_q [DEPTH];

`ifdef TONE_SEQ_LOOP_EN
    assign loop_on = loop;
`else
    assign loop_on = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                table_q[i] <= '0;
            end
        end else if (wr_en && ({1'b0, wr_addr} < DEPTH_L)) begin
            table_q[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            step_q <= '0;
            timer  <= '0;
            done   <= 1'b0;
        end else begin
            state  <= state_nxt;
            step_q <= step_nxt;
            timer  <= timer_nxt;
            done   <= done_nxt;
        end
    end

    // The divider is held in reload while idle so tone stays low and it is
    // already primed with entry 0 when playback begins.
    always_comb begin
        state_nxt = state;
        step_nxt  = step_q;
        timer_nxt = timer;
        done_nxt  = 1'b0;
        reload    = 1'b0;
        case (state)
            IDLE: begin
                reload    = 1'b1;
                step_nxt  = '0;
                timer_nxt = '0;
                if (start && !stop) begin
                    state_nxt = PLAY;
                end
            end
            PLAY: begin
                if (stop) begin
                    state_nxt = IDLE;
                    step_nxt  = '0;
                    timer_nxt = '0;
                    reload    = 1'b1;
                end else if (timer == LAST_TICK) begin
                    timer_nxt = '0;
                    reload    = 1'b1;
                    if (step_q != LAST_STEP) begin
                        step_nxt = step_q + 1'b1;
                    end else if (loop_on) begin
                        step_nxt = '0;
                    end else begin
                        state_nxt = IDLE;
                        step_nxt  = '0;
                        done_nxt  = 1'b1;
                    end
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // step_nxt equals step_q except on a step change, so this feeds the
    // current entry to mid-step toggles and the new entry on a boundary.
    tone_div #(.W(ENTRY_W)) u_div (
        .clk    (clk),
        .rst_n  (rst_n),
        .reload (reload),
        .half   (table_q[step_nxt]),
        .tone   (tone_out)
    );

    assign busy = (state == PLAY);
    assign step = step_q;

endmodule

// File: tb/tb_tone_seq.sv
// Directed bench for tone_seq (DEPTH=4, STEP_CYCLES=16, table {2,0,4,1})
// plus a DEPTH=5 instance for out-of-range writes.
module tb_tone_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0, stop = 1'b0, wr_en = 1'b0;
    logic [1:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic       busy, tone_out, done;
    logic [1:0] step;
`ifdef TONE_SEQ_LOOP_EN
    logic       loop = 1'b0;
    logic       loop2 = 1'b0;
`endif

    logic       start2 = 1'b0, stop2 = 1'b0, wr_en2 = 1'b0;
    logic [2:0] wr_addr2 = '0;
    logic [7:0] wr_data2 = '0;
    logic       busy2, tone2, done2;
    logic [2:0] step2;

    int n_tests = 0;
    int n_fail  = 0;
    int tbl [4] = '{2, 0, 4, 1};

    always #5 clk = ~clk;

    tone_seq #(.ENTRY_W(8), .DEPTH(4), .STEP_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
`ifdef TONE_SEQ_LOOP_EN
        .loop(loop),
`endif
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .step(step), .tone_out(tone_out), .done(done)
    );

    tone_seq #(.ENTRY_W(8), .DEPTH(5), .STEP_CYCLES(4)) dut_odd (
        .clk(clk), .rst_n(rst_n), .start(start2), .stop(stop2),
`ifdef TONE_SEQ_LOOP_EN
        .loop(loop2),
`endif
        .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2),
        .busy(busy2), .step(step2), .tone_out(tone2), .done(done2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_entry(input logic [1:0] a, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic play_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Tone level at `e` edges after start: floor(offset/E) toggles so far.
    function automatic logic exp_tone(input int e);
        int o, ent;
        o   = e % 16;
        ent = tbl[(e / 16) % 4];
        return (ent == 0) ? 1'b0 : 1'(((o / ent) % 2));
    endfunction

    initial begin
        int hi, dn;

        #1;
        check("reset_busy", busy, 0);
        check("reset_step", step, 0);
        check("reset_tone", tone_out, 0);
        check("reset_done", done, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 4; i++) write_entry(2'(i), 8'(tbl[i]));

        // Full one-shot run with per-edge expectations.
        play_start();
        check("start_busy", busy, 1);
        check("start_step", step, 0);
        check("start_tone", tone_out, 0);
        for (int e = 1; e < 64; e++) begin
            tick();
            check($sformatf("run_tone_e%0d", e), tone_out, exp_tone(e));
            check($sformatf("run_step_e%0d", e), step, e / 16);
            check($sformatf("run_busy_e%0d", e), busy, 1);
            check($sformatf("run_done_e%0d", e), done, 0);
        end
        tick();
        check("end_busy", busy, 0);
        check("end_done", done, 1);
        check("end_step", step, 0);
        check("end_tone", tone_out, 0);
        tick();
        check("end_done_one_cycle", done, 0);

        // Restart ignored in PLAY; stop at edge 40.
        play_start();
        for (int e = 1; e < 40; e++) begin
            start = (e == 10);
            tick();
            if (e == 16) check("restart_ignored_step", step, 1);
        end
        start = 1'b0;
        check("pre_stop_tone", tone_out, 1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("stop_busy", busy, 0);
        check("stop_tone", tone_out, 0);
        check("stop_step", step, 0);
        check("stop_done", done, 0);
        dn = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            dn += int'(done);
        end
        check("stop_no_done", dn, 0);
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        check("start_stop_idle", busy, 0);
        tick();
        check("start_stop_idle2", busy, 0);

        // Write to playing entry 2 mid-count: 4 -> 3 at the next toggle.
        play_start();
        for (int e = 1; e < 34; e++) tick();
        wr_en = 1'b1; wr_addr = 2'd2; wr_data = 8'd3;
        tick();
        wr_en = 1'b0;
        check("wr_e34_tone", tone_out, 0);
        for (int e = 35; e < 48; e++) begin
            tick();
            check($sformatf("wr_tone_e%0d", e), tone_out,
                  (e < 36) ? 0 : ((((e - 36) / 3) % 2) == 0));
        end
        tick();
        check("wr_e48_step", step, 3);
        check("wr_e48_tone", tone_out, 0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        write_entry(2'd2, 8'd4);

        // Out-of-range address on a DEPTH=5 instance leaves the table alone.
        wr_en2 = 1'b1; wr_addr2 = 3'd0; wr_data2 = 8'd1;
        tick();
        wr_addr2 = 3'd5; wr_data2 = 8'd3;
        tick();
        wr_en2 = 1'b0;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        hi = 0; dn = 0;
        for (int e = 1; e < 20; e++) begin
            tick();
            hi += int'(tone2);
            dn += int'(done2);
        end
        check("oor_tone_highs", hi, 2);
        check("oor_no_early_done", dn, 0);
        tick();
        check("oor_done", done2, 1);
        check("oor_busy", busy2, 0);

`ifdef TONE_SEQ_LOOP_EN
        loop = 1'b1;
        play_start();
        for (int e = 1; e < 64; e++) tick();
        tick();
        check("loop_step", step, 0);
        check("loop_busy", busy, 1);
        check("loop_done", done, 0);
        for (int e = 65; e <= 80; e++) tick();
        loop = 1'b0;
        dn = 0;
        for (int e = 81; e < 128; e++) begin
            tick();
            dn += int'(done);
        end
        check("loop_no_early_done", dn, 0);
        check("loop_busy_127", busy, 1);
        tick();
        check("loop_done_128", done, 1);
        check("loop_busy_128", busy, 0);
`endif

        // Reset during playback (step 2, tone high) clears outputs at once.
        play_start();
        for (int e = 1; e <= 37; e++) tick();
        check("pre_rst_tone", tone_out, 1);
        check("pre_rst_step", step, 2);
        rst_n = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_step", step, 0);
        check("rst_tone", tone_out, 0);
        check("rst_done", done, 0);
        tick();
        rst_n = 1'b1;
        tick();
        play_start();
        hi = 0;
        for (int e = 1; e < 64; e++) begin
            tick();
            hi += int'(tone_out);
        end
        check("rst_table_cleared", hi, 0);
        tick();
        check("rst_replay_done", done, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
